// File: rtl/imem_resp.sv
// Instruction-memory responder: a one-entry line buffer in front of a word array
// with a multi-cycle miss path, a host load port and a saturating miss counter.
module imem_resp #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic [31:0] i_addr_pc,
    input  logic        i_con_flush,
    input  logic        i_con_load,
    input  logic [31:0] i_addr_load,
    input  logic [31:0] i_data_load,
    output logic [31:0] o_data_instr,
    output logic        o_con_ifstall,
    output logic [15:0] o_cnt_miss
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] idx_t;
    typedef enum logic {IDLE, FETCH} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    idx_t        idx_q, idx_d;
    logic        buf_vld_q, buf_vld_d;
    idx_t        buf_tag_q, buf_tag_d;
    logic [31:0] buf_data_q;
    logic [15:0] miss_q, miss_d;
    logic        fill;
    logic [31:0] mem [DEPTH];

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic addr_ok(input logic [31:0] a);
        return (a[31:DEPTH_LOG2+2] == '0) && (a[1:0] == 2'b00);
    endfunction

    idx_t pc_idx, ld_idx;
    logic pc_ok, ld_wr, hit;

    assign pc_idx = i_addr_pc[DEPTH_LOG2+1:2];
    assign ld_idx = i_addr_load[DEPTH_LOG2+1:2];
    assign pc_ok  = addr_ok(i_addr_pc);
    assign ld_wr  = i_con_load && addr_ok(i_addr_load);
    assign hit    = (state_q == IDLE) && buf_vld_q && pc_ok &&
                    (buf_tag_q == pc_idx) && !i_con_load;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        buf_vld_d     = buf_vld_q;
        buf_tag_d     = buf_tag_q;
        miss_d        = miss_q;
        fill          = 1'b0;
        o_data_instr  = NOP_INSTR;
        o_con_ifstall = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_con_load) begin
                    o_con_ifstall = 1'b1;
                end else if (!pc_ok) begin
                    o_con_ifstall = 1'b0;
                end else if (hit) begin
                    o_data_instr = buf_data_q;
                end else begin
                    o_con_ifstall = 1'b1;
                    idx_d         = pc_idx;
                    cnt_d         = 3'(WAIT_CYCLES);
                    miss_d        = sat_inc16(miss_q);
                    state_d       = FETCH;
                end
            end
            FETCH: begin
                o_con_ifstall = 1'b1;
                // A redirect or a moved PC abandons the access; the new PC is looked up next cycle.
                if (i_con_flush || !pc_ok || (pc_idx != idx_q)) begin
                    state_d = IDLE;
                end else if (i_con_load) begin
                    cnt_d = cnt_q;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    fill      = 1'b1;
                    buf_tag_d = idx_q;
                    buf_vld_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (ld_wr && (ld_idx == buf_tag_q))
            buf_vld_d = 1'b0;

        if (!i_nrst) begin
            o_data_instr  = NOP_INSTR;
            o_con_ifstall = 1'b0;
        end
    end

    assign o_cnt_miss = miss_q;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            buf_vld_q <= 1'b0;
            buf_tag_q <= '0;
            miss_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            buf_vld_q <= buf_vld_d;
            buf_tag_q <= buf_tag_d;
            miss_q    <= miss_d;
        end
    end

    // Array and buffer data carry no reset; valid gates their use.
    always_ff @(posedge i_clk) begin
        if (ld_wr)
            mem[ld_idx] <= i_data_load;
        if (fill)
            buf_data_q <= mem[idx_q];
    end

endmodule
